// File: rtl/memory_stage_pkg.sv
// Types shared by the memory stage: control word, access FSM states and funct3 encodings.
package memory_stage_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mem_state_e;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } ld_funct3_e;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } st_funct3_e;

   // funct3[1:0] carries the access size for both loads and stores
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef struct packed {
      logic       rf_w_v;
      logic [4:0] rd_addr;
      logic       dmem_r_v;
      logic       dmem_w_v;
      logic [2:0] funct3;
   } rvga_cword;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         SIZE_HALF: return off[0];
         SIZE_WORD: return |off;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/memory_stage_lsu_align.sv
// Combinational lane logic: store byte enables / replicated write data, load lane extract and extend.
module memory_stage_lsu_align
   import memory_stage_pkg::*;
#(
   parameter int width_p    = 32,
   parameter int be_width_p = 4
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            off,
   input  logic [width_p-1:0]    st_data,
   input  logic [width_p-1:0]    rdata,
   output logic [be_width_p-1:0] be,
   output logic [width_p-1:0]    wdata,
   output logic [width_p-1:0]    ld_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        sext;

   assign byte_lane = rdata[{off, 3'b000} +: 8];
   assign half_lane = rdata[{off[1], 4'b0000} +: 16];
   assign sext      = ~funct3[2];

   always_comb begin
      be      = '1;
      wdata   = st_data;
      ld_data = rdata;
      case (funct3[1:0])
         SIZE_BYTE: begin
            be      = be_width_p'(1) << off;
            wdata   = {be_width_p{st_data[7:0]}};
            ld_data = {{(width_p-8){sext & byte_lane[7]}}, byte_lane};
         end
         SIZE_HALF: begin
            be      = be_width_p'(3) << off;
            wdata   = {(be_width_p/2){st_data[15:0]}};
            ld_data = {{(width_p-16){sext & half_lane[15]}}, half_lane};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers the execute outputs and runs one data-memory access per op.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int width_p    = 32,
   parameter int be_width_p = width_p/8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_v_i,
   output logic                  stall_v_o,
   input  rvga_cword             cword_i,
   input  logic [width_p-1:0]    alu_result_i,
   input  logic [width_p-1:0]    st_data_i,
   output rvga_cword             cword_o,
   output logic [width_p-1:0]    memory_rd_data_o,
   output logic                  misalign_v_o,
   output logic                  dmem_v_o,
   input  logic                  dmem_ready_i,
   output logic                  dmem_w_v_o,
   output logic [width_p-1:0]    dmem_addr_o,
   output logic [be_width_p-1:0] dmem_be_o,
   output logic [width_p-1:0]    dmem_wdata_o,
   input  logic                  dmem_resp_v_i,
   input  logic [width_p-1:0]    dmem_rdata_i
);

   rvga_cword             cword_reg;
   logic [width_p-1:0]    alu_reg;
   logic [width_p-1:0]    st_reg;
   logic [width_p-1:0]    ld_data_reg;
   mem_state_e            state_reg;
   mem_state_e            state_next;
   logic                  advance;
   logic                  go_in;
   logic                  mem_op;
   logic                  is_store;
   logic                  misaligned;
   logic [be_width_p-1:0] be;
   logic [width_p-1:0]    wdata;
   logic [width_p-1:0]    ld_ext;

   // Decided on the incoming op so an aligned access is already in REQ on its first stage cycle
   assign go_in      = (cword_i.dmem_r_v | cword_i.dmem_w_v) &
                       ~is_misaligned(cword_i.funct3, alu_result_i[1:0]);
   assign mem_op     = cword_reg.dmem_r_v | cword_reg.dmem_w_v;
   assign is_store   = cword_reg.dmem_w_v;
   assign misaligned = mem_op & is_misaligned(cword_reg.funct3, alu_reg[1:0]);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cword_reg <= '0;
         alu_reg   <= '0;
         st_reg    <= '0;
      end else if (advance) begin
         cword_reg <= cword_i;
         alu_reg   <= alu_result_i;
         st_reg    <= st_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ld_data_reg <= '0;
      end else if (state_reg == RESP && dmem_resp_v_i) begin
         ld_data_reg <= ld_ext;
      end
   end

   always_comb begin
      state_next = state_reg;
      dmem_v_o   = 1'b0;
      stall_v_o  = 1'b0;
      case (state_reg)
         REQ: begin
            dmem_v_o  = 1'b1;
            stall_v_o = ~(is_store & dmem_ready_i);
         end
         RESP:    stall_v_o = 1'b1;
         default: ;
      endcase
      advance = ~(stall_v_i | stall_v_o);
      case (state_reg)
         IDLE, DONE: begin
            if (advance) state_next = go_in ? REQ : IDLE;
         end
         REQ: begin
            if (dmem_ready_i) begin
               // An accepted store retires in place when the pipeline moves on this same edge
               if (!is_store)     state_next = RESP;
               else if (!advance) state_next = DONE;
               else               state_next = go_in ? REQ : IDLE;
            end
         end
         RESP: begin
            if (dmem_resp_v_i) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   memory_stage_lsu_align #(
      .width_p    (width_p),
      .be_width_p (be_width_p)
   ) u_align (
      .funct3  (cword_reg.funct3),
      .off     (alu_reg[1:0]),
      .st_data (st_reg),
      .rdata   (dmem_rdata_i),
      .be      (be),
      .wdata   (wdata),
      .ld_data (ld_ext)
   );

   assign dmem_w_v_o       = dmem_v_o & is_store;
   assign dmem_addr_o      = {alu_reg[width_p-1:2], 2'b00};
   assign dmem_be_o        = dmem_w_v_o ? be : '0;
   assign dmem_wdata_o     = wdata;
   assign misalign_v_o     = misaligned;
   assign cword_o          = cword_reg;
   assign memory_rd_data_o = cword_reg.dmem_r_v ? (misaligned ? '0 : ld_data_reg) : alu_reg;

endmodule
